target_rx_sequencer: RTL and testbench

- Target-side HDR-DDR frame sequencer. It owns the enable and mode select of the target receive deserializer.
- Walks the deserializer through a write frame in order: header, command word, data words, CRC word.
- Checks the deserializer's per-mode done and error flags, and reports frame completion or a coded error to the target engine.
- Sits between the HDR-entry detector / target engine and the receive deserializer.

---
 rtl/target_ddr_pkg.sv | 48 ++++
 rtl/target_rx_sequencer_if.sv | 19 +
 rtl/target_rx_watchdog.sv | 24 ++
 rtl/target_rx_sequencer.sv | 147 ++++++++++++++
 tb/tb_target_rx_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/target_ddr_pkg.sv
// Shared encodings for the target HDR-DDR receive path: deserializer modes,
// engine decisions, frame error codes and the rx sequencer state set.
package target_ddr_pkg;

  localparam logic [3:0] MODE_INIT  = 4'd0;
  localparam logic [3:0] MODE_PRE   = 4'd1;
  localparam logic [3:0] MODE_DATA  = 4'd2;
  localparam logic [3:0] MODE_CCC   = 4'd3;
  localparam logic [3:0] MODE_PAR   = 4'd4;
  localparam logic [3:0] MODE_TOKEN = 4'd5;
  localparam logic [3:0] MODE_CRC   = 4'd6;
  localparam logic [3:0] MODE_ZEROS = 4'd8;
  localparam logic [3:0] MODE_SPRE  = 4'd9;

  localparam logic [1:0] DEC_NOT_ME  = 2'b00;
  localparam logic [1:0] DEC_DIRECT  = 2'b01;
  localparam logic [1:0] DEC_BCAST   = 2'b10;
  localparam logic [1:0] DEC_HDR_ERR = 2'b11;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_HEADER   = 3'd1;
  localparam logic [2:0] ERR_SPRE     = 3'd2;
  localparam logic [2:0] ERR_PARITY   = 3'd3;
  localparam logic [2:0] ERR_TOKEN    = 3'd4;
  localparam logic [2:0] ERR_CRC      = 3'd5;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd6;
  localparam logic [2:0] ERR_OVERFLOW = 3'd7;

  typedef enum logic [3:0] {
    ST_IDLE, ST_HDR, ST_SPRE, ST_ZEROS, ST_CCC, ST_CPAR,
    ST_PRE, ST_DATA, ST_DPAR, ST_TOKEN, ST_CRC, ST_FAIL
  } seq_state_t;

  function automatic logic [3:0] state_mode(seq_state_t s);
    case (s)
      ST_SPRE:         return MODE_SPRE;
      ST_ZEROS:        return MODE_ZEROS;
      ST_CCC:          return MODE_CCC;
      ST_CPAR, ST_DPAR: return MODE_PAR;
      ST_PRE:          return MODE_PRE;
      ST_DATA:         return MODE_DATA;
      ST_TOKEN:        return MODE_TOKEN;
      ST_CRC:          return MODE_CRC;
      default:         return MODE_INIT;
    endcase
  endfunction

endpackage

// File: rtl/target_rx_sequencer_if.sv
// Sequencer <-> receive deserializer bus: enable/mode out, done/flags back.
interface target_rx_sequencer_if;
  logic       o_rx_en;
  logic [3:0] o_rx_mode;
  logic       i_rx_mode_done;
  logic       i_rx_error_flag;
  logic       i_rx_pre;
  logic       i_rx_rnw;

  modport master (
    output o_rx_en, o_rx_mode,
    input  i_rx_mode_done, i_rx_error_flag, i_rx_pre, i_rx_rnw
  );

  modport slave (
    input  o_rx_en, o_rx_mode,
    output i_rx_mode_done, i_rx_error_flag, i_rx_pre, i_rx_rnw
  );
endinterface

// File: rtl/target_rx_watchdog.sv
// Stall counter: counts enabled cycles since the last clear and flags
// expiry once TIMEOUT_CYCLES cycles have gone by without one.
module target_rx_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 12
) (
  input  logic i_sys_clk,
  input  logic i_sys_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  assign expired = enable && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Holds at the terminal count; the owner leaves the state on expiry.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst || clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/target_rx_sequencer.sv
// HDR-DDR write-frame sequencer: steps the rx deserializer through
// header, CCC, data words and CRC, and reports done / coded error.
module target_rx_sequencer
  import target_ddr_pkg::*;
#(
  parameter  int MAX_WORDS      = 16,
  parameter  int TIMEOUT_CYCLES = 4096,
  parameter  int CNT_W          = 12,
  localparam int WC_W           = $clog2(MAX_WORDS + 1)
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  target_rx_sequencer_if.master rx,
  input  logic                  i_frame_start,
  input  logic                  i_abort,
  input  logic [1:0]            i_engine_decision,
  output logic                  o_busy,
  output logic                  o_byte_valid,
  output logic [WC_W-1:0]       o_word_count,
  output logic                  o_tx_handoff,
  output logic                  o_frame_done,
  output logic                  o_frame_err,
  output logic [2:0]            o_err_code
);

  seq_state_t state, state_nxt;
  logic       second_byte;
  logic       active, done, err, wd_expired;
  logic       byte_nxt, fdone_nxt, handoff_nxt, word_inc;
  logic [2:0] fail_code;

  assign done   = rx.i_rx_mode_done;
  assign err    = rx.i_rx_error_flag;
  assign active = (state != ST_IDLE) && (state != ST_FAIL);

  assign o_busy       = (state != ST_IDLE);
  assign o_frame_err  = (state == ST_FAIL);
  assign rx.o_rx_en   = active;
  assign rx.o_rx_mode = state_mode(state);

  target_rx_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .i_sys_clk (i_sys_clk),
    .i_sys_rst (i_sys_rst),
    .clear     (done || i_abort || !active),
    .enable    (active),
    .expired   (wd_expired)
  );

  always_comb begin
    state_nxt   = state;
    fail_code   = ERR_NONE;
    byte_nxt    = 1'b0;
    fdone_nxt   = 1'b0;
    handoff_nxt = 1'b0;
    word_inc    = 1'b0;
    unique case (state)
      ST_IDLE: if (i_frame_start) state_nxt = ST_HDR;
      ST_FAIL: state_nxt = ST_IDLE;
      default: begin
        // Abort beats done, done beats a same-cycle timeout.
        if (i_abort) begin
          state_nxt = ST_IDLE;
        end else if (done) begin
          case (state)
            ST_HDR: begin
              case (i_engine_decision)
                DEC_HDR_ERR: fail_code = ERR_HEADER;
                DEC_NOT_ME:  state_nxt = ST_IDLE;
                default: begin
                  if (rx.i_rx_rnw) begin
                    handoff_nxt = 1'b1;
                    state_nxt   = ST_IDLE;
                  end else begin
                    state_nxt = ST_SPRE;
                  end
                end
              endcase
            end
            ST_SPRE:  if (err) fail_code = ERR_SPRE; else state_nxt = ST_ZEROS;
            ST_ZEROS: state_nxt = ST_CCC;
            ST_CCC: begin
              byte_nxt  = 1'b1;
              state_nxt = ST_CPAR;
            end
            ST_CPAR, ST_DPAR: if (err) fail_code = ERR_PARITY; else state_nxt = ST_PRE;
            ST_PRE: begin
              if (!rx.i_rx_pre) state_nxt = ST_TOKEN;
              else if (o_word_count == WC_W'(MAX_WORDS)) fail_code = ERR_OVERFLOW;
              else state_nxt = ST_DATA;
            end
            ST_DATA: begin
              byte_nxt = 1'b1;
              if (second_byte) begin
                word_inc  = 1'b1;
                state_nxt = ST_DPAR;
              end
            end
            ST_TOKEN: if (err) fail_code = ERR_TOKEN; else state_nxt = ST_CRC;
            ST_CRC: begin
              if (err) begin
                fail_code = ERR_CRC;
              end else begin
                fdone_nxt = 1'b1;
                state_nxt = ST_IDLE;
              end
            end
            default: ;
          endcase
        end else if (wd_expired) begin
          fail_code = ERR_TIMEOUT;
        end
        if (fail_code != ERR_NONE) state_nxt = ST_FAIL;
      end
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state        <= ST_IDLE;
      second_byte  <= 1'b0;
      o_word_count <= '0;
      o_err_code   <= ERR_NONE;
      o_byte_valid <= 1'b0;
      o_frame_done <= 1'b0;
      o_tx_handoff <= 1'b0;
    end else begin
      state        <= state_nxt;
      o_byte_valid <= byte_nxt;
      o_frame_done <= fdone_nxt;
      o_tx_handoff <= handoff_nxt;
      if (state == ST_IDLE && i_frame_start) begin
        o_word_count <= '0;
        o_err_code   <= ERR_NONE;
      end else begin
        if (word_inc && o_word_count != WC_W'(MAX_WORDS)) o_word_count <= o_word_count + 1'b1;
        if (fail_code != ERR_NONE) o_err_code <= fail_code;
      end
      // Low/high byte of the current data word.
      if (state == ST_DATA && done && !i_abort) second_byte <= ~second_byte;
      else if (state != ST_DATA) second_byte <= 1'b0;
    end
  end

endmodule

// File: tb/tb_target_rx_sequencer.sv
// Scoreboard bench: frames are expanded from protocol rules into expected
// modes/events; a negedge monitor pops and compares whatever the DUT shows.
module tb_target_rx_sequencer;
  import target_ddr_pkg::*;

  localparam int MAXW = 2;
  localparam int TMO  = 100;
  localparam int CW   = 7;
  localparam int WCW  = $clog2(MAXW + 1);

  localparam int K_NONE = 0, K_BYTE = 1, K_DONE = 2, K_ERR = 3, K_HAND = 4;

  typedef struct {
    int         kind;
    logic [2:0] code;
    int         wc;
  } ev_t;

  typedef struct {
    logic [3:0] mode;
    bit         err;
    bit         pre;
    int         kind;
    logic [2:0] code;
    int         wc;
    int         wcn;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           frame_start = 1'b0;
  logic           abort_i     = 1'b0;
  logic [1:0]     dec         = 2'b00;
  logic           busy, byte_valid, tx_handoff, frame_done, frame_err;
  logic [WCW-1:0] word_count;
  logic [2:0]     err_code;

  target_rx_sequencer_if rx_bus ();

  target_rx_sequencer #(
    .MAX_WORDS      (MAXW),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CW)
  ) dut (
    .i_sys_clk         (clk),
    .i_sys_rst         (rst),
    .rx                (rx_bus.master),
    .i_frame_start     (frame_start),
    .i_abort           (abort_i),
    .i_engine_decision (dec),
    .o_busy            (busy),
    .o_byte_valid      (byte_valid),
    .o_word_count      (word_count),
    .o_tx_handoff      (tx_handoff),
    .o_frame_done      (frame_done),
    .o_frame_err       (frame_err),
    .o_err_code        (err_code)
  );

  int         n_chk  = 0;
  int         n_fail = 0;
  ev_t        evq[$];
  logic [3:0] modeq[$];
  step_t      st[$];
  int         words_m;
  logic [2:0] last_code = 3'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares mode on every done the DUT consumes, and every pulse.
  ev_t        mon_e;
  logic [3:0] mon_m;
  int         mon_k, mon_n;
  always @(negedge clk) begin
    if (rx_bus.i_rx_mode_done && busy) begin
      if (modeq.size() == 0) chk("mode_unexpected_done", 1, 0);
      else begin
        mon_m = modeq.pop_front();
        chk("rx_mode", rx_bus.o_rx_mode, mon_m);
        chk("rx_en_active", rx_bus.o_rx_en, 1);
      end
    end
    mon_n = int'(byte_valid === 1'b1) + int'(frame_done === 1'b1) +
            int'(frame_err === 1'b1) + int'(tx_handoff === 1'b1);
    if (mon_n > 1) chk("pulse_overlap", mon_n, 1);
    mon_k = (byte_valid === 1'b1) ? K_BYTE : (frame_done === 1'b1) ? K_DONE :
            (frame_err === 1'b1) ? K_ERR : (tx_handoff === 1'b1) ? K_HAND : K_NONE;
    if (mon_k != K_NONE) begin
      if (evq.size() == 0) chk("unexpected_pulse_kind", mon_k, K_NONE);
      else begin
        mon_e = evq.pop_front();
        chk("event_kind", mon_k, mon_e.kind);
        chk("err_code", err_code, mon_e.code);
        chk("word_count", word_count, mon_e.wc);
        if (mon_k == K_ERR || mon_k == K_HAND) chk("rx_en_off", rx_bus.o_rx_en, 0);
      end
    end
  end

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic [3:0] m, input bit e, input bit p, input int k,
                     input logic [2:0] c, input int w);
    step_t s;
    s.mode = m; s.err = e; s.pre = p; s.kind = k; s.code = c; s.wc = w; s.wcn = words_m;
    st.push_back(s);
  endtask

  // Expand a frame into the ordered deserializer steps it should produce.
  task automatic build(input logic [1:0] d, input bit rnw, input logic [15:0] pre_mask,
                       input int err_pct, input int force_step);
    bit fin, p, e;
    int pidx;
    st.delete();
    words_m = 0;
    pidx    = 0;
    fin     = 1'b0;
    if (d == DEC_HDR_ERR)     add(MODE_INIT, rb(), 0, K_ERR, ERR_HEADER, 0);
    else if (d == DEC_NOT_ME) add(MODE_INIT, rb(), 0, K_NONE, 0, 0);
    else if (rnw)             add(MODE_INIT, rb(), 0, K_HAND, 0, 0);
    else begin
      add(MODE_INIT, rb(), 0, K_NONE, 0, 0);
      e = (st.size() == force_step) || ($urandom_range(0, 99) < err_pct);
      if (e) add(MODE_SPRE, 1, 0, K_ERR, ERR_SPRE, 0);
      else begin
        add(MODE_SPRE, 0, 0, K_NONE, 0, 0);
        add(MODE_ZEROS, rb(), 0, K_NONE, 0, 0);
        add(MODE_CCC, rb(), 0, K_BYTE, 0, 0);
        e = (st.size() == force_step) || ($urandom_range(0, 99) < err_pct);
        if (e) add(MODE_PAR, 1, 0, K_ERR, ERR_PARITY, 0);
        else begin
          add(MODE_PAR, 0, 0, K_NONE, 0, 0);
          while (!fin) begin
            p = (pidx < 16) ? pre_mask[pidx] : 1'b0;
            pidx++;
            if (p && words_m == MAXW) begin
              add(MODE_PRE, rb(), 1, K_ERR, ERR_OVERFLOW, words_m);
              fin = 1'b1;
            end else if (p) begin
              add(MODE_PRE, rb(), 1, K_NONE, 0, 0);
              add(MODE_DATA, rb(), 0, K_BYTE, 0, words_m);
              add(MODE_DATA, rb(), 0, K_BYTE, 0, words_m + 1);
              words_m++;
              e = (st.size() == force_step) || ($urandom_range(0, 99) < err_pct);
              if (e) begin add(MODE_PAR, 1, 0, K_ERR, ERR_PARITY, words_m); fin = 1'b1; end
              else add(MODE_PAR, 0, 0, K_NONE, 0, 0);
            end else begin
              add(MODE_PRE, rb(), 0, K_NONE, 0, 0);
              e = (st.size() == force_step) || ($urandom_range(0, 99) < err_pct);
              if (e) add(MODE_TOKEN, 1, 0, K_ERR, ERR_TOKEN, words_m);
              else begin
                add(MODE_TOKEN, 0, 0, K_NONE, 0, 0);
                e = (st.size() == force_step) || ($urandom_range(0, 99) < err_pct);
                if (e) add(MODE_CRC, 1, 0, K_ERR, ERR_CRC, words_m);
                else   add(MODE_CRC, 0, 0, K_DONE, ERR_NONE, words_m);
              end
              fin = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cut_kind: 0 none, 1 stall into timeout, 2 abort, 3 reset -- applied at cut_step.
  task automatic run_frame(input logic [1:0] d, input bit rnw, input logic [15:0] pre_mask,
                           input int err_pct, input int force_step, input int cut_kind,
                           input int cut_step, input bit cut_done);
    ev_t e;
    build(d, rnw, pre_mask, err_pct, force_step);
    dec              = d;
    rx_bus.i_rx_rnw  = rnw;
    frame_start      = 1'b1;
    last_code        = ERR_NONE;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < st.size(); i++) begin
      repeat ($urandom_range(0, 3)) tick();
      if (cut_kind != 0 && i == cut_step) begin
        if (cut_kind == 1) begin
          e.kind = K_ERR; e.code = ERR_TIMEOUT; e.wc = st[i].wcn;
          evq.push_back(e);
          last_code = ERR_TIMEOUT;
          repeat (TMO + 3) tick();
        end else if (cut_kind == 2) begin
          abort_i                = 1'b1;
          rx_bus.i_rx_mode_done  = cut_done;
          rx_bus.i_rx_error_flag = rb();
          rx_bus.i_rx_pre        = rb();
          if (cut_done) modeq.push_back(st[i].mode);
          tick();
          abort_i               = 1'b0;
          rx_bus.i_rx_mode_done = 1'b0;
          @(negedge clk);
          chk("abort_busy", busy, 0);
          chk("abort_rx_en", rx_bus.o_rx_en, 0);
          tick();
        end else begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          @(negedge clk);
          chk("rst_busy", busy, 0);
          chk("rst_rx_en", rx_bus.o_rx_en, 0);
          chk("rst_rx_mode", rx_bus.o_rx_mode, 0);
          chk("rst_word_count", word_count, 0);
          chk("rst_err_code", err_code, 0);
          chk("rst_pulses", {byte_valid, frame_done, frame_err, tx_handoff}, 0);
          tick();
        end
        break;
      end
      rx_bus.i_rx_mode_done  = 1'b1;
      rx_bus.i_rx_error_flag = st[i].err;
      rx_bus.i_rx_pre        = st[i].pre;
      modeq.push_back(st[i].mode);
      if (st[i].kind != K_NONE) begin
        e.kind = st[i].kind; e.code = st[i].code; e.wc = st[i].wc;
        evq.push_back(e);
        if (st[i].kind == K_ERR) last_code = st[i].code;
      end
      tick();
      rx_bus.i_rx_mode_done  = 1'b0;
      rx_bus.i_rx_error_flag = rb();
      rx_bus.i_rx_pre        = rb();
    end
    repeat (3) tick();
    @(negedge clk);
    chk("idle_after_frame", busy, 0);
    chk("err_code_hold", err_code, last_code);
    tick();
  endtask

  initial begin
    rx_bus.i_rx_mode_done  = 1'b0;
    rx_bus.i_rx_error_flag = 1'b0;
    rx_bus.i_rx_pre        = 1'b0;
    rx_bus.i_rx_rnw        = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_rx_en", rx_bus.o_rx_en, 0);
    chk("reset_rx_mode", rx_bus.o_rx_mode, 0);
    chk("reset_word_count", word_count, 0);
    chk("reset_err_code", err_code, 0);
    chk("reset_pulses", {byte_valid, frame_done, frame_err, tx_handoff}, 0);
    rst = 1'b0;
    tick();

    run_frame(DEC_DIRECT, 0, 16'b011, 0, -1, 0, -1, 0);  // 2-word write
    run_frame(DEC_HDR_ERR, 0, 16'b0, 0, -1, 0, -1, 0);
    run_frame(DEC_NOT_ME, 0, 16'b0, 0, -1, 0, -1, 0);
    run_frame(DEC_BCAST, 1, 16'b0, 0, -1, 0, -1, 0);     // read -> handoff
    run_frame(DEC_DIRECT, 0, 16'b011, 0, 8, 0, -1, 0);   // DPAR error, word 1
    run_frame(DEC_BCAST, 0, 16'b0, 0, 7, 0, -1, 0);      // CRC error
    run_frame(DEC_DIRECT, 0, 16'b111, 0, -1, 0, -1, 0);  // overflow
    run_frame(DEC_DIRECT, 0, 16'b1, 0, -1, 1, 6, 0);     // stall in DATA
    run_frame(DEC_DIRECT, 0, 16'b1, 0, -1, 2, 3, 1);     // abort + done in CCC
    run_frame(DEC_DIRECT, 0, 16'b1, 0, -1, 3, 7, 0);     // reset mid-DATA
    run_frame(DEC_DIRECT, 0, 16'b01, 0, -1, 0, -1, 0);

    for (int f = 0; f < 150; f++) begin
      logic [1:0]  rd;
      logic [15:0] rm;
      int          ck;
      rd = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(1, 2)) : 2'($urandom_range(0, 3));
      rm = 16'($urandom());
      ck = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
      run_frame(rd, ($urandom_range(0, 9) == 0), rm, 5, -1, ck, $urandom_range(0, 10), rb());
    end

    repeat (4) tick();
    chk("mode_queue_drained", modeq.size(), 0);
    chk("event_queue_drained", evq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL run_time_limit: actual=expired expected=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
